// File: rtl/inst_fetch_buf.sv
// Fetch stage: owns the fetch PC, issues single-outstanding word reads to imem and
// buffers returned words in a small FIFO that presents the head instruction to ctrl.
module inst_fetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [4:0]        opcode,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  output logic              illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {S_RUN, S_DROP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       word;
  } fetch_ent_t;

  state_t            state, state_nxt;
  logic              pending, pending_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_pc;

  fetch_ent_t        fifo_mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occ_nxt;

  logic push, pop, room, can_req, issue;
  fetch_ent_t head;
  logic redir_lsb_unused;

  assign redir_lsb_unused = ^redir_pc[1:0];

  // Responses are only kept in RUN; a redirect in the response cycle discards them.
  assign push    = imem_rvalid && (state == S_RUN) && !redir_valid;
  assign pop     = inst_valid && inst_ready;
  assign occ_nxt = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign room    = occ_nxt < (CW+1)'(DEPTH);
  assign can_req = (state == S_RUN) ? (!pending || imem_rvalid) : imem_rvalid;
  // rst term keeps the request low while reset is held.
  assign issue   = rst && !redir_valid && can_req && room;

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    fetch_pc_nxt = fetch_pc;
    if (imem_rvalid) pending_nxt = 1'b0;
    if (issue) begin
      pending_nxt  = 1'b1;
      fetch_pc_nxt = fetch_pc + ADDR_W'(4);
    end
    if (redir_valid) begin
      fetch_pc_nxt = {redir_pc[ADDR_W-1:2], 2'b00};
      state_nxt    = (pending && !imem_rvalid) ? S_DROP : S_RUN;
    end else if (state == S_DROP && imem_rvalid) begin
      state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      pending  <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (issue) req_pc <= fetch_pc;
      if (redir_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= occ_nxt[CW-1:0];
      end
    end
  end

  // Storage needs no reset: contents are masked until count says they are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{pc: req_pc, word: imem_rdata};
  end

  assign head       = fifo_mem[rd_ptr];
  assign inst_valid = (count != '0);
  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;
  assign inst       = inst_valid ? head.word : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;
  assign opcode     = inst[6:2];
  assign func3      = inst[14:12];
  assign func7      = inst[31:25];
  assign illegal    = inst_valid && (inst[1:0] != 2'b11);

endmodule
